// File: rtl/veerwolf_axi_pkg.sv
// rtl/veerwolf_axi_pkg.sv - shared AXI response/burst codes, FSM states and address helper
package veerwolf_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WRESP   = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

    // Address of the next beat. WRAP bursts are treated as plain INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [31:0] result;
        case (burst)
            BURST_FIXED:            result = addr;
            BURST_INCR, BURST_WRAP: result = addr + (32'd1 << size);
            default:                result = addr + (32'd1 << size);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/veerwolf_axi_ram_mem.sv
// rtl/veerwolf_axi_ram_mem.sv - single-port 64-bit byte-enabled synchronous RAM
// Ports: clk; we/be/wdata write one word at idx; re loads rdata from idx on
//        the next rising edge (rdata holds while re is low).
module veerwolf_axi_ram_mem #(
    parameter int DEPTH     = 8192,
    parameter int IDX_W     = 13,
    parameter     INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             we,
    input  logic [7:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [63:0]      wdata,
    input  logic             re,
    output logic [63:0]      rdata
);

    logic [63:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/veerwolf_axi_ram.sv
// rtl/veerwolf_axi_ram.sv - AXI4 responder over a single-port 64-bit RAM
// Ports: clk, rstn (async, active-low); AXI4 slave channels AW/W/B/AR/R
//        (i_* inputs, o_* outputs); o_init_done/o_init_error mirror the
//        status pins of the DDR controller this block stands in for.
module veerwolf_axi_ram #(
    parameter int          ID_WIDTH  = 6,
    parameter logic [31:0] MEM_SIZE  = 32'h10000,
    parameter              INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ID_WIDTH-1:0] i_awid,
    input  logic [31:0]         i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [2:0]          i_awsize,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [63:0]         i_wdata,
    input  logic [7:0]          i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [ID_WIDTH-1:0] o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready,
    input  logic [ID_WIDTH-1:0] i_arid,
    input  logic [31:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    output logic [ID_WIDTH-1:0] o_rid,
    output logic [63:0]         o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready,
    output logic                o_init_done,
    output logic                o_init_error
);

    import veerwolf_axi_pkg::*;

    localparam int ADDR_BITS = $clog2(MEM_SIZE);
    localparam int IDX_W     = (ADDR_BITS > 3) ? ADDR_BITS - 3 : 1;
    localparam int DEPTH     = int'(MEM_SIZE >> 3);

    state_t                state;
    logic                  pref_wr;   // next AW/AR collision goes to the write side
    logic [ID_WIDTH-1:0]   id_q;
    logic [31:0]           addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q;     // sticky for writes, per beat for reads
    logic                  init_q;

    logic                  idle;
    logic                  grant_rd;
    logic                  grant_wr;
    logic                  addr_oor;
    logic                  last_beat;
    logic                  mem_we;
    logic                  mem_re;
    logic [IDX_W-1:0]      mem_idx;
    logic [63:0]           mem_rdata;

    // Write bursts end on wlast, so the AW length is never needed.
    logic                  unused_awlen;
    assign unused_awlen = ^i_awlen;

    assign idle      = rstn && (state == ST_IDLE);
    assign grant_rd  = i_arvalid && (!i_awvalid || !pref_wr);
    assign grant_wr  = i_awvalid && (!i_arvalid || pref_wr);
    assign addr_oor  = (addr_q >= MEM_SIZE);
    assign last_beat = (beat_q == len_q);
    assign mem_idx   = IDX_W'(addr_q >> 3);
    assign mem_we    = (state == ST_WRITE) && i_wvalid && !addr_oor;
    assign mem_re    = (state == ST_RD_ADDR);

    veerwolf_axi_ram_mem #(
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (i_wstrb),
        .idx   (mem_idx),
        .wdata (i_wdata),
        .re    (mem_re),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            pref_wr <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            init_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    // History only moves on a real collision.
                    if (i_awvalid && i_arvalid) begin
                        pref_wr <= grant_rd;
                    end
                    if (grant_rd) begin
                        id_q    <= i_arid;
                        addr_q  <= i_araddr;
                        len_q   <= i_arlen;
                        size_q  <= i_arsize;
                        burst_q <= i_arburst;
                        beat_q  <= '0;
                        state   <= ST_RD_ADDR;
                    end else if (grant_wr) begin
                        id_q    <= i_awid;
                        addr_q  <= i_awaddr;
                        size_q  <= i_awsize;
                        burst_q <= i_awburst;
                        err_q   <= 1'b0;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (i_wvalid) begin
                        if (addr_oor) begin
                            err_q <= 1'b1;
                        end
                        addr_q <= next_addr(addr_q, size_q, burst_q);
                        if (i_wlast) begin
                            state <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (i_bready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    err_q <= addr_oor;
                    state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (i_rready) begin
                        if (last_beat) begin
                            state <= ST_IDLE;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= next_addr(addr_q, size_q, burst_q);
                            state  <= ST_RD_ADDR;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_awready    = idle && grant_wr;
    assign o_arready    = idle && grant_rd;
    assign o_wready     = (state == ST_WRITE);
    assign o_bvalid     = (state == ST_WRESP);
    assign o_bid        = id_q;
    assign o_bresp      = (o_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign o_rvalid     = (state == ST_RD_DATA);
    assign o_rid        = id_q;
    assign o_rdata      = err_q ? 64'd0 : mem_rdata;
    assign o_rresp      = (o_rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign o_rlast      = o_rvalid && last_beat;
    assign o_init_done  = init_q;
    assign o_init_error = 1'b0;

endmodule

// File: tb/tb_veerwolf_axi_ram.sv
// tb/tb_veerwolf_axi_ram.sv - self-checking bench for veerwolf_axi_ram
module tb_veerwolf_axi_ram;

    localparam int ID_W = 6;
    localparam int MSZ  = 'h400;

    logic            clk = 1'b0;
    logic            rstn;
    logic [ID_W-1:0] i_awid, i_arid, o_bid, o_rid;
    logic [31:0]     i_awaddr, i_araddr;
    logic [7:0]      i_awlen, i_arlen, i_wstrb;
    logic [2:0]      i_awsize, i_arsize;
    logic [1:0]      i_awburst, i_arburst, o_bresp, o_rresp;
    logic            i_awvalid, o_awready, i_wlast, i_wvalid, o_wready;
    logic            o_bvalid, i_bready, i_arvalid, o_arready;
    logic            o_rlast, o_rvalid, i_rready, o_init_done, o_init_error;
    logic [63:0]     i_wdata, o_rdata;

    veerwolf_axi_ram #(.ID_WIDTH(ID_W), .MEM_SIZE(32'(MSZ)), .INIT_FILE("")) dut (
        .clk(clk), .rstn(rstn),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
        .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_init_done(o_init_done), .o_init_error(o_init_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Byte-level reference memory
    logic [7:0]  mbytes [MSZ];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    logic [31:0]     w_addr, r_addr;
    logic [1:0]      w_burst, r_burst, w_exp;
    logic [2:0]      w_size, r_size;
    logic [ID_W-1:0] w_id, r_id;
    logic [7:0]      r_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst,
                                              input logic [2:0] size, input int k);
        if (burst == 2'b00) return a;
        return a + 32'(k) * (32'd1 << size);
    endfunction

    function automatic logic [63:0] mword(input logic [31:0] a);
        logic [63:0] w;
        int base;
        base = int'(a) & ~7;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = mbytes[base + b];
        return w;
    endfunction

    task automatic aw_start(input logic [31:0] a, input logic [1:0] burst,
                            input logic [2:0] size, input logic [7:0] awlen);
        w_addr = a; w_burst = burst; w_size = size; w_id = ID_W'($urandom);
        i_awid = w_id; i_awaddr = a; i_awlen = awlen; i_awsize = size;
        i_awburst = burst; i_awvalid = 1'b1;
    endtask

    task automatic aw_hs();
        int n = 0;
        while (o_awready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        chk("aw_handshake_in_time", n < 50, 1);
        @(posedge clk);
        @(negedge clk);
        i_awvalid = 1'b0;
    endtask

    task automatic w_beats(input int nbeats);
        logic [31:0] a;
        logic err = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            a = beat_addr(w_addr, w_burst, w_size, k);
            if (a >= 32'(MSZ)) err = 1'b1;
            else for (int b = 0; b < 8; b++)
                if (ws[k][b]) mbytes[(int'(a) & ~7) + b] = wd[k][8*b +: 8];
            if ($urandom_range(0, 3) == 0) begin i_wvalid = 1'b0; @(negedge clk); end
            i_wvalid = 1'b1; i_wdata = wd[k]; i_wstrb = ws[k]; i_wlast = (k == nbeats - 1);
            begin
                int n = 0;
                #1;
                while (o_wready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
                chk("w_handshake_in_time", n < 50, 1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        w_exp = err ? 2'b10 : 2'b00;
    endtask

    task automatic b_phase();
        int n = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        i_bready = 1'b1;
        #1;
        while (o_bvalid !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        chk("b_valid_in_time", n < 50, 1);
        chk("b_id", o_bid, w_id);
        chk("b_resp", o_bresp, w_exp);
        @(posedge clk);
        @(negedge clk);
        i_bready = 1'b0;
        #1;
    endtask

    task automatic ar_start(input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        r_addr = a; r_len = len; r_burst = burst; r_size = size; r_id = ID_W'($urandom);
        i_arid = r_id; i_araddr = a; i_arlen = len; i_arsize = size;
        i_arburst = burst; i_arvalid = 1'b1;
    endtask

    task automatic ar_hs();
        int n = 0;
        while (o_arready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        chk("ar_handshake_in_time", n < 50, 1);
        @(posedge clk);
        @(negedge clk);
        i_arvalid = 1'b0;
        #1;
    endtask

    // Entered just after an AR handshake edge; every beat must appear exactly
    // one edge later than this point (two edges after the handshake edge).
    task automatic r_beats(input int stall_beat, input int stall_cycles);
        logic [31:0] a;
        logic [63:0] exp_d;
        logic [1:0]  exp_r;
        logic        exp_l;
        for (int k = 0; k <= int'(r_len); k++) begin
            a     = beat_addr(r_addr, r_burst, r_size, k);
            exp_d = (a >= 32'(MSZ)) ? 64'd0 : mword(a);
            exp_r = (a >= 32'(MSZ)) ? 2'b10 : 2'b00;
            exp_l = (k == int'(r_len));
            chk("r_valid_low_one_edge_after_hs", o_rvalid, 0);
            @(negedge clk); #1;
            chk("r_valid_two_edges_after_hs", o_rvalid, 1);
            chk("r_data", o_rdata, exp_d);
            chk("r_resp", o_rresp, exp_r);
            chk("r_last", o_rlast, exp_l);
            chk("r_id", o_rid, r_id);
            if (k == stall_beat) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk); #1;
                    chk("stall_valid", o_rvalid, 1);
                    chk("stall_data", o_rdata, exp_d);
                    chk("stall_last", o_rlast, exp_l);
                    chk("stall_id", o_rid, r_id);
                end
            end
            i_rready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            i_rready = 1'b0;
            #1;
        end
        chk("r_valid_after_burst", o_rvalid, 0);
    endtask

    task automatic axi_write(input logic [31:0] a, input int nbeats, input logic [1:0] burst,
                             input logic [2:0] size, input logic [7:0] awlen);
        @(negedge clk);
        aw_start(a, burst, size, awlen);
        #1;
        aw_hs();
        w_beats(nbeats);
        b_phase();
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input int stall_beat, input int stall_cycles);
        @(negedge clk);
        ar_start(a, len, burst, size);
        #1;
        ar_hs();
        r_beats(stall_beat, stall_cycles);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not complete");
    end

    initial begin
        rstn = 1'b0;
        i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0;
        i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_bready = 1'b0;
        i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0;
        i_rready = 1'b0;
        i_awvalid = 1'b1; i_arvalid = 1'b1; i_wvalid = 1'b1;

        // Reset state, with valids pushed high to prove readys are held low
        repeat (3) @(negedge clk);
        #1;
        chk("rst_awready", o_awready, 0);
        chk("rst_arready", o_arready, 0);
        chk("rst_wready", o_wready, 0);
        chk("rst_bvalid", o_bvalid, 0);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_bresp", o_bresp, 0);
        chk("rst_rresp", o_rresp, 0);
        chk("rst_rlast", o_rlast, 0);
        chk("rst_init_done", o_init_done, 0);
        chk("rst_init_error", o_init_error, 0);
        i_awvalid = 1'b0; i_arvalid = 1'b0; i_wvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("init_done_before_edge", o_init_done, 0);
        @(negedge clk); #1;
        chk("init_done_after_edge", o_init_done, 1);

        // Fill the whole RAM in one burst; awlen 0 shows wlast sets the length
        for (int k = 0; k < MSZ / 8; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
        axi_write(32'h0, MSZ / 8, 2'b01, 3'd3, 8'd0);

        // Single write / read
        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        axi_write(32'h100, 1, 2'b01, 3'd3, 8'd0);
        axi_read(32'h100, 8'd0, 2'b01, 3'd3, -1, 0);
        chk("single_rdata_literal", mword(32'h100), 64'h1122334455667788);

        // INCR burst with partial strobe on beat 1
        for (int k = 0; k < 4; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
        ws[1] = 8'h0F;
        axi_write(32'h200, 4, 2'b01, 3'd3, 8'd3);
        axi_read(32'h200, 8'd3, 2'b01, 3'd3, -1, 0);

        // Arbitration: after reset read wins the first collision, write the next
        reset_pulse();
        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        aw_start(32'h300, 2'b01, 3'd3, 8'd0);
        ar_start(32'h100, 8'd0, 2'b01, 3'd3);
        #1;
        chk("col1_arready", o_arready, 1);
        chk("col1_awready", o_awready, 0);
        ar_hs();
        chk("col1_awready_busy", o_awready, 0);
        r_beats(-1, 0);
        chk("col1_awready_after_read", o_awready, 1);
        aw_hs();
        w_beats(1);
        b_phase();
        @(negedge clk);
        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        ar_start(32'h300, 8'd0, 2'b01, 3'd3);
        aw_start(32'h308, 2'b01, 3'd3, 8'd0);
        #1;
        chk("col2_awready", o_awready, 1);
        chk("col2_arready", o_arready, 0);
        aw_hs();
        w_beats(1);
        b_phase();
        chk("col2_arready_after_write", o_arready, 1);
        ar_hs();
        r_beats(-1, 0);

        // Out of range: SLVERR, no write (word 1 would be the truncated alias)
        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        axi_write(32'(MSZ + 8), 1, 2'b01, 3'd3, 8'd0);
        axi_read(32'h8, 8'd0, 2'b01, 3'd3, -1, 0);
        axi_read(32'(MSZ + 8), 8'd0, 2'b01, 3'd3, -1, 0);
        for (int k = 0; k < 3; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
        axi_write(32'(MSZ - 16), 3, 2'b01, 3'd3, 8'd2);
        axi_read(32'(MSZ - 16), 8'd2, 2'b01, 3'd3, -1, 0);

        // Backpressure mid-burst and FIXED bursts
        axi_read(32'h200, 8'd3, 2'b01, 3'd3, 1, 5);
        axi_read(32'h100, 8'd2, 2'b00, 3'd3, -1, 0);
        wd[0] = {$urandom, $urandom}; ws[0] = 8'h03;
        wd[1] = {$urandom, $urandom}; ws[1] = 8'h0C;
        wd[2] = {$urandom, $urandom}; ws[2] = 8'hF0;
        axi_write(32'h180, 3, 2'b00, 3'd3, 8'd2);
        axi_read(32'h180, 8'd0, 2'b01, 3'd3, -1, 0);

        // Narrow beats and WRAP-as-INCR
        for (int k = 0; k < 4; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'($urandom); end
        axi_write(32'h10, 4, 2'b01, 3'd2, 8'd3);
        axi_read(32'h10, 8'd3, 2'b01, 3'd2, -1, 0);
        for (int k = 0; k < 2; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
        axi_write(32'h40, 2, 2'b10, 3'd3, 8'd1);
        axi_read(32'h40, 8'd1, 2'b10, 3'd3, -1, 0);

        // Randomised traffic against the byte model
        for (int t = 0; t < 25; t++) begin
            logic [31:0] a;
            logic [1:0]  bu;
            logic [2:0]  sz;
            int          nb;
            a  = $urandom_range(0, MSZ + 40);
            bu = 2'($urandom_range(0, 2));
            sz = 3'($urandom_range(0, 3));
            nb = $urandom_range(1, 8);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < nb; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'($urandom); end
                axi_write(a, nb, bu, sz, 8'($urandom));
            end else begin
                axi_read(a, 8'(nb - 1), bu, sz, $urandom_range(0, nb - 1), $urandom_range(0, 3));
            end
        end

        // Reset in the middle of a read burst
        @(negedge clk);
        ar_start(32'h200, 8'd7, 2'b01, 3'd3);
        #1;
        ar_hs();
        @(negedge clk); #1;
        chk("midrst_rvalid_before", o_rvalid, 1);
        rstn = 1'b0;
        #1;
        chk("midrst_rvalid_async", o_rvalid, 0);
        chk("midrst_rlast_async", o_rlast, 0);
        chk("midrst_init_done", o_init_done, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("midrst_init_done_before_edge", o_init_done, 0);
        @(negedge clk); #1;
        chk("midrst_init_done_after_edge", o_init_done, 1);
        i_rready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("midrst_no_r_beat", o_rvalid, 0);
            chk("midrst_no_b_beat", o_bvalid, 0);
        end
        i_rready = 1'b0;
        axi_read(32'h100, 8'd0, 2'b01, 3'd3, -1, 0);
        axi_read(32'h200, 8'd3, 2'b01, 3'd3, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
